// File: rtl/decoder_scan.sv
`default_nettype none
// ============================================================================
// Module   : decoder_scan
// Purpose  : Registered IN_W-to-2^IN_W one-hot decoder with direct-decode
//            and auto-scan (programmable dwell) modes.
// Revision : 1.0
// ============================================================================
module decoder_scan #(
    parameter int IN_W    = 2,
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [IN_W-1:0]      in,
    input  logic                 in_valid,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [2**IN_W-1:0]   out,
    output logic [IN_W-1:0]      idx,
    output logic                 out_valid,
    output logic                 wrap
);
    localparam int OUT_W = 2**IN_W;
    localparam logic [IN_W-1:0] c_last_idx = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t             r_state;
    logic [DWELL_W-1:0] r_cnt;
    logic [IN_W-1:0]    r_idx;
    logic [OUT_W-1:0]   r_out;
    logic               r_out_valid;
    logic               r_wrap;

    state_t             w_state_nxt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic [IN_W-1:0]    w_idx_nxt;
    logic               w_valid_nxt;
    logic               w_wrap_nxt;
    logic [OUT_W-1:0]   w_out_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_valid_nxt;
            r_wrap      <= w_wrap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_wrap_nxt  = 1'b0;

        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else if (!mode) begin
            w_state_nxt = ST_DIRECT;
            if (in_valid) begin
                w_idx_nxt   = in;
                w_valid_nxt = 1'b1;
            end else if (r_state == ST_DIRECT) begin
                w_idx_nxt   = r_idx;
                w_valid_nxt = r_out_valid;
            end
        end else begin
            w_state_nxt = ST_SCAN;
            w_valid_nxt = 1'b1;
            // Any entry into scan, from whichever state, restarts at line 0.
            if (r_state != ST_SCAN) begin
                w_idx_nxt = '0;
                w_cnt_nxt = '0;
            end else if (r_cnt >= dwell) begin
                w_cnt_nxt  = '0;
                w_idx_nxt  = r_idx + IN_W'(1);
                w_wrap_nxt = (r_idx == c_last_idx);
            end else begin
                w_cnt_nxt = r_cnt + DWELL_W'(1);
                w_idx_nxt = r_idx;
            end
        end

        w_out_nxt = w_valid_nxt ? (OUT_W'(1) << w_idx_nxt) : '0;
    end

    assign out       = r_out;
    assign idx       = r_idx;
    assign out_valid = r_out_valid;
    assign wrap      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_scan
// Purpose  : Self-checking bench for decoder_scan (IN_W=2, DWELL_W=8).
// Revision : 1.0
// ============================================================================
module tb_decoder_scan;
    logic       clk = 1'b0;
    logic       rst, en, mode, in_valid;
    logic [1:0] in;
    logic [7:0] dwell;
    logic [3:0] out;
    logic [1:0] idx;
    logic       out_valid, wrap;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0=idle 1=direct 2=scan, plus active line and time on it.
    int m_mode = 0;
    int m_line = 0;
    int m_held = 0;
    bit m_live = 0;
    bit m_wrap = 0;

    typedef struct {
        logic       rst, en, mode, in_valid;
        logic [1:0] in;
        logic [7:0] dwell;
        logic [3:0] e_out;
        logic [1:0] e_idx;
        logic       e_valid, e_wrap;
        string      name;
    } vec_t;
    vec_t vecs[$];

    decoder_scan #(.IN_W(2), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in),
        .in_valid(in_valid), .dwell(dwell), .out(out), .idx(idx),
        .out_valid(out_valid), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_wrap = 0;
        if (rst || !en) begin
            m_mode = 0; m_line = 0; m_held = 0; m_live = 0;
        end else if (!mode) begin
            if (in_valid) begin
                m_line = int'(in); m_live = 1;
            end else if (m_mode != 1) begin
                m_line = 0; m_live = 0;
            end
            m_mode = 1; m_held = 0;
        end else begin
            if (m_mode != 2) begin
                m_line = 0; m_held = 0;
            end else if (m_held >= int'(dwell)) begin
                m_held = 0;
                m_wrap = (m_line == 3);
                m_line = (m_line + 1) % 4;
            end else begin
                m_held++;
            end
            m_live = 1; m_mode = 2;
        end
    endtask

    task automatic cycle();
        logic [3:0] e_out;
        @(posedge clk);
        model_step();
        @(negedge clk);
        e_out = m_live ? (4'b0001 << m_line) : 4'b0000;
        chk("model_out", 32'(out), 32'(e_out));
        chk("model_idx", 32'(idx), 32'(m_line));
        chk("model_valid", 32'(out_valid), 32'(m_live));
        chk("model_wrap", 32'(wrap), 32'(m_wrap));
        // Invariant: blank with valid low, or one-hot matching idx with valid high.
        chk("invariant", 32'(out), out_valid ? 32'(4'b0001 << idx) : 32'd0);
    endtask

    task automatic add_vec(input logic r, e, md, iv, input logic [1:0] i, input logic [7:0] d,
                           input logic [3:0] eo, input logic [1:0] ei, input logic ev, ew,
                           input string nm);
        vec_t v;
        v.rst = r; v.en = e; v.mode = md; v.in_valid = iv; v.in = i; v.dwell = d;
        v.e_out = eo; v.e_idx = ei; v.e_valid = ev; v.e_wrap = ew; v.name = nm;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1; en = 1; mode = 1; in = 0; in_valid = 0; dwell = 0;

        // Reset hold, release into scan, then direct decode of every code.
        add_vec(1, 1, 1, 0, 2'd0, 8'd0, 4'b0000, 2'd0, 0, 0, "rst_hold0");
        add_vec(1, 1, 1, 0, 2'd0, 8'd0, 4'b0000, 2'd0, 0, 0, "rst_hold1");
        add_vec(1, 1, 1, 0, 2'd0, 8'd0, 4'b0000, 2'd0, 0, 0, "rst_hold2");
        add_vec(0, 1, 1, 0, 2'd0, 8'd0, 4'b0001, 2'd0, 1, 0, "rst_release");
        add_vec(0, 1, 0, 1, 2'd0, 8'd0, 4'b0001, 2'd0, 1, 0, "dir_00");
        add_vec(0, 1, 0, 1, 2'd1, 8'd0, 4'b0010, 2'd1, 1, 0, "dir_01");
        add_vec(0, 1, 0, 1, 2'd2, 8'd0, 4'b0100, 2'd2, 1, 0, "dir_10");
        add_vec(0, 1, 0, 1, 2'd3, 8'd0, 4'b1000, 2'd3, 1, 0, "dir_11");
        add_vec(0, 1, 0, 0, 2'd0, 8'd0, 4'b1000, 2'd3, 1, 0, "dir_hold");
        add_vec(0, 0, 0, 1, 2'd2, 8'd0, 4'b0000, 2'd0, 0, 0, "disable");

        foreach (vecs[k]) begin
            rst = vecs[k].rst; en = vecs[k].en; mode = vecs[k].mode;
            in_valid = vecs[k].in_valid; in = vecs[k].in; dwell = vecs[k].dwell;
            cycle();
            chk({vecs[k].name, "_out"}, 32'(out), 32'(vecs[k].e_out));
            chk({vecs[k].name, "_idx"}, 32'(idx), 32'(vecs[k].e_idx));
            chk({vecs[k].name, "_valid"}, 32'(out_valid), 32'(vecs[k].e_valid));
            chk({vecs[k].name, "_wrap"}, 32'(wrap), 32'(vecs[k].e_wrap));
        end

        // Scan with dwell=2: each line three cycles, wrap on the 13th cycle.
        rst = 1; cycle(); rst = 0; en = 1; mode = 1; dwell = 8'd2; in_valid = 0;
        for (int k = 0; k <= 12; k++) begin
            cycle();
            chk("scan2_out", 32'(out), 32'(4'b0001 << ((k / 3) % 4)));
            chk("scan2_wrap", 32'(wrap), 32'(k == 12));
        end

        // Dwell=0: advance every cycle, wrap every 4th.
        rst = 1; cycle(); rst = 0; dwell = 8'd0;
        for (int k = 0; k < 9; k++) begin
            cycle();
            chk("scan0_idx", 32'(idx), 32'(k % 4));
            chk("scan0_wrap", 32'(wrap), 32'(k > 0 && k % 4 == 0));
        end

        // Lowering dwell mid-hold advances on the next edge.
        rst = 1; cycle(); rst = 0; dwell = 8'd5;
        for (int k = 0; k < 5; k++) cycle();
        chk("live_hold_idx", 32'(idx), 32'd0);
        dwell = 8'd1; cycle();
        chk("live_drop_idx", 32'(idx), 32'd1);

        // Mode / enable switching.
        rst = 1; cycle(); rst = 0; dwell = 8'd0;
        cycle(); cycle(); cycle();
        chk("sw_scan_idx", 32'(idx), 32'd2);
        mode = 0; in_valid = 0; cycle();
        chk("sw_dir_blank", 32'({out_valid, out}), 32'd0);
        cycle();
        chk("sw_dir_still_blank", 32'({out_valid, out}), 32'd0);
        in = 2'd3; in_valid = 1; cycle();
        chk("sw_dir_11", 32'(out), 32'(4'b1000));
        in_valid = 0; mode = 1; cycle();
        chk("sw_rescan", 32'(out), 32'(4'b0001));
        en = 0; cycle();
        chk("sw_disable", 32'({out_valid, out}), 32'd0);

        // Reset mid-scan at idx=3, cnt=1.
        en = 1; mode = 1; dwell = 8'd2;
        for (int k = 0; k <= 10; k++) cycle();
        chk("midrst_pre_idx", 32'(idx), 32'd3);
        rst = 1; cycle();
        chk("midrst_clear", 32'({wrap, out_valid, idx, out}), 32'd0);
        rst = 0; cycle();
        chk("midrst_restart", 32'(out), 32'(4'b0001));

        // Random stimulus against the reference model.
        for (int k = 0; k < 400; k++) begin
            rst      = ($urandom_range(0, 39) == 0);
            en       = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 11) == 0) mode = ~mode;
            in       = 2'($urandom_range(0, 3));
            in_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) dwell = 8'($urandom_range(0, 4));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
